// File: rtl/airi5c_prenorm_sequencer.sv
// ---------------------------------------------------------------------------
// airi5c_prenorm_sequencer
//
// Shares one airi5c pre-normalizer between up to three FPU source operands
// (rs1/rs2/rs3). On an accepted start the raw single-precision operands are
// captured. One operand per cycle is then classified and presented to the
// external pre-normalizer. Its combinational result is stored in that slot's
// result registers, and done pulses for one cycle when the sequence ends.
//
// Ports
//   clk, n_reset            core clock (rising edge), async active-low reset
//   start, op_cnt, kill     request, operand count (0..3), pipeline flush
//   op_a/op_b/op_c          raw IEEE-754 operands, captured on accepted start
//   ready, busy, done       IDLE / any NORM_x state / one-cycle completion
//   pn_zero, pn_denormal,
//   pn_man, pn_exp          operand presented to the shared pre-normalizer
//   pn_man_res, pn_exp_res  normalized mantissa / unbiased exponent back
//   man_x, exp_x, sgn_x     registered per-slot results (x = a, b, c)
// ---------------------------------------------------------------------------
module airi5c_prenorm_sequencer #(
    parameter int NUM_OPS = 3
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [1:0]  op_cnt,
    input  logic        kill,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] op_c,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        pn_zero,
    output logic        pn_denormal,
    output logic [23:0] pn_man,
    output logic [7:0]  pn_exp,
    input  logic [23:0] pn_man_res,
    input  logic [9:0]  pn_exp_res,
    output logic [23:0] man_a,
    output logic [23:0] man_b,
    output logic [23:0] man_c,
    output logic [9:0]  exp_a,
    output logic [9:0]  exp_b,
    output logic [9:0]  exp_c,
    output logic        sgn_a,
    output logic        sgn_b,
    output logic        sgn_c
);

    // Largest operand count this instance will ever sequence.
    localparam logic [1:0] MAX_CNT = (NUM_OPS >= 3) ? 2'd3 :
                                     ((NUM_OPS == 2) ? 2'd2 : 2'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM_A,
        S_NORM_B,
        S_NORM_C,
        S_DONE
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  eff_cnt_reg;
    logic [1:0]  start_cnt;
    logic        accept;
    logic [1:0]  slot;

    // Flattened per-slot storage, slot gi at bit offset gi*width.
    logic [95:0] op_in;
    logic [92:0] mag_all;      // captured operands without sign bit
    logic [71:0] man_all;
    logic [29:0] exp_all;
    logic [2:0]  sgn_all;
    logic [30:0] cur_mag;

    assign op_in = {op_c, op_b, op_a};

    // Operand count clamped to the number of slots this instance has.
    assign start_cnt = (op_cnt > MAX_CNT) ? MAX_CNT : op_cnt;
    assign accept    = ready && start && !kill;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg   <= S_IDLE;
            eff_cnt_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                eff_cnt_reg <= start_cnt;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        slot       = 2'd0;
        unique case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = (start_cnt == 2'd0) ? S_DONE : S_NORM_A;
                end
            end
            S_NORM_A: begin
                busy       = 1'b1;
                slot       = 2'd0;
                state_next = (eff_cnt_reg >= 2'd2) ? S_NORM_B : S_DONE;
            end
            S_NORM_B: begin
                busy       = 1'b1;
                slot       = 2'd1;
                state_next = (eff_cnt_reg == 2'd3) ? S_NORM_C : S_DONE;
            end
            S_NORM_C: begin
                busy       = 1'b1;
                slot       = 2'd2;
                state_next = S_DONE;
            end
            S_DONE: begin
                // A flush in the completion cycle suppresses the pulse.
                done       = !kill;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Flush wins over everything, including a start in IDLE.
        if (kill) begin
            state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Per-slot operand capture and result registers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slots
            if (gi < NUM_OPS) begin : g_slot
                logic [31:0] op_q;
                logic [23:0] man_q;
                logic [9:0]  exp_q;
                logic        sgn_q;
                logic        load;

                always_ff @(posedge clk or negedge n_reset) begin
                    if (!n_reset) begin
                        op_q <= 32'h0;
                    end else if (accept) begin
                        op_q <= op_in[gi*32 +: 32];
                    end
                end

                // A flushed cycle must not overwrite the slot being processed.
                assign load = busy && !kill && (slot == 2'(gi));

                always_ff @(posedge clk or negedge n_reset) begin
                    if (!n_reset) begin
                        man_q <= 24'h0;
                        exp_q <= 10'h0;
                        sgn_q <= 1'b0;
                    end else if (load) begin
                        man_q <= pn_man_res;
                        exp_q <= pn_exp_res;
                        sgn_q <= op_q[31];
                    end
                end

                assign mag_all[gi*31 +: 31] = op_q[30:0];
                assign man_all[gi*24 +: 24] = man_q;
                assign exp_all[gi*10 +: 10] = exp_q;
                assign sgn_all[gi]          = sgn_q;
            end else begin : g_unused
                // Slots beyond NUM_OPS are never written.
                assign mag_all[gi*31 +: 31] = 31'h0;
                assign man_all[gi*24 +: 24] = 24'h0;
                assign exp_all[gi*10 +: 10] = 10'h0;
                assign sgn_all[gi]          = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand presented to the shared pre-normalizer (all zero when idle)
    // ------------------------------------------------------------------
    always_comb begin
        cur_mag = 31'h0;
        if (busy) begin
            unique case (slot)
                2'd0:    cur_mag = mag_all[30:0];
                2'd1:    cur_mag = mag_all[61:31];
                default: cur_mag = mag_all[92:62];
            endcase
        end
    end

    // Inf/NaN (exponent 0xFF) fall through as normal numbers.
    assign pn_zero     = busy && (cur_mag[30:23] == 8'h00) && (cur_mag[22:0] == 23'h0);
    assign pn_denormal = busy && (cur_mag[30:23] == 8'h00) && (cur_mag[22:0] != 23'h0);
    assign pn_man      = {(cur_mag[30:23] != 8'h00), cur_mag[22:0]};
    assign pn_exp      = cur_mag[30:23];

    assign man_a = man_all[23:0];
    assign man_b = man_all[47:24];
    assign man_c = man_all[71:48];
    assign exp_a = exp_all[9:0];
    assign exp_b = exp_all[19:10];
    assign exp_c = exp_all[29:20];
    assign sgn_a = sgn_all[0];
    assign sgn_b = sgn_all[1];
    assign sgn_c = sgn_all[2];

endmodule

// File: tb/tb_airi5c_prenorm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_airi5c_prenorm_sequencer
//
// Directed bench for the pre-normalizer sequencer. A behavioural stand-in for
// the shared pre-normalizer closes the loop on each DUT. A transaction-level
// reference model (operation phase counter + float normalization arithmetic)
// is compared with the main DUT on every falling edge. Literal expectations
// pin the model. A second instance with NUM_OPS=2 checks the slot clamp.
// ---------------------------------------------------------------------------
module tb_airi5c_prenorm_sequencer;

    localparam int NOPS = 3;

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  op_cnt = 2'd0;
    logic        kill = 1'b0;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic [31:0] op_c = 32'h0;

    logic        ready, busy, done, pn_zero, pn_denormal;
    logic [23:0] pn_man, pn_man_res;
    logic [7:0]  pn_exp;
    logic [9:0]  pn_exp_res;
    logic [23:0] man_a, man_b, man_c;
    logic [9:0]  exp_a, exp_b, exp_c;
    logic        sgn_a, sgn_b, sgn_c;

    logic        ready_2, busy_2, done_2, pn_zero_2, pn_denormal_2;
    logic [23:0] pn_man_2, pn_man_res_2;
    logic [7:0]  pn_exp_2;
    logic [9:0]  pn_exp_res_2;
    logic [23:0] man_a_2, man_b_2, man_c_2;
    logic [9:0]  exp_a_2, exp_b_2, exp_c_2;
    logic        sgn_a_2, sgn_b_2, sgn_c_2;

    always #5 clk = ~clk;

    airi5c_prenorm_sequencer #(.NUM_OPS(3)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .op_cnt(op_cnt), .kill(kill),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .ready(ready), .busy(busy), .done(done),
        .pn_zero(pn_zero), .pn_denormal(pn_denormal), .pn_man(pn_man), .pn_exp(pn_exp),
        .pn_man_res(pn_man_res), .pn_exp_res(pn_exp_res),
        .man_a(man_a), .man_b(man_b), .man_c(man_c),
        .exp_a(exp_a), .exp_b(exp_b), .exp_c(exp_c),
        .sgn_a(sgn_a), .sgn_b(sgn_b), .sgn_c(sgn_c)
    );

    airi5c_prenorm_sequencer #(.NUM_OPS(2)) dut2 (
        .clk(clk), .n_reset(n_reset), .start(start2), .op_cnt(op_cnt), .kill(kill),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .ready(ready_2), .busy(busy_2), .done(done_2),
        .pn_zero(pn_zero_2), .pn_denormal(pn_denormal_2), .pn_man(pn_man_2), .pn_exp(pn_exp_2),
        .pn_man_res(pn_man_res_2), .pn_exp_res(pn_exp_res_2),
        .man_a(man_a_2), .man_b(man_b_2), .man_c(man_c_2),
        .exp_a(exp_a_2), .exp_b(exp_b_2), .exp_c(exp_c_2),
        .sgn_a(sgn_a_2), .sgn_b(sgn_b_2), .sgn_c(sgn_c_2)
    );

    // Stand-in for the shared pre-normalizer: works from the flags/fields.
    function automatic logic [33:0] pn_unit(input logic z, input logic d,
                                            input logic [23:0] m, input logic [7:0] e);
        int msb;
        if (z) return 34'h0;
        if (d) begin
            msb = 0;
            for (int i = 0; i < 23; i++) if (m[i]) msb = i;
            return {10'h382 - 10'(23 - msb), m << (23 - msb)};
        end
        return {{2'b00, e} - 10'd127, m};
    endfunction

    always_comb {pn_exp_res, pn_man_res} = pn_unit(pn_zero, pn_denormal, pn_man, pn_exp);
    always_comb {pn_exp_res_2, pn_man_res_2} = pn_unit(pn_zero_2, pn_denormal_2, pn_man_2, pn_exp_2);

    // Reference normalization straight from the float's value.
    function automatic logic [33:0] ref_norm(input logic [31:0] f);
        int e;
        int fr;
        int sh;
        e  = int'(f[30:23]);
        fr = int'(f[22:0]);
        sh = 0;
        if (e == 0 && fr == 0) return 34'h0;
        if (e == 0) begin
            while (fr < (1 << 23)) begin
                fr = fr * 2;
                sh++;
            end
            return {10'(-126 - sh), 24'(fr)};
        end
        return {10'(e - 127), 24'(fr + (1 << 23))};
    endfunction

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: phase -1 = idle, 0..eff-1 = slot being normalized,
    // phase == eff = completion cycle.
    int          m_phase = -1;
    int          m_eff = 0;
    logic [31:0] m_ops [3];
    logic [23:0] m_man [3];
    logic [9:0]  m_exp [3];
    logic        m_sgn [3];

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_phase <= -1;
            m_eff   <= 0;
            for (int i = 0; i < 3; i++) begin
                m_ops[i] <= 32'h0;
                m_man[i] <= 24'h0;
                m_exp[i] <= 10'h0;
                m_sgn[i] <= 1'b0;
            end
        end else if (kill) begin
            m_phase <= -1;
        end else if (m_phase < 0) begin
            if (start) begin
                m_ops[0] <= op_a;
                m_ops[1] <= op_b;
                m_ops[2] <= op_c;
                m_eff    <= (int'(op_cnt) > NOPS) ? NOPS : int'(op_cnt);
                m_phase  <= 0;
            end
        end else if (m_phase < m_eff) begin
            m_man[m_phase] <= ref_norm(m_ops[m_phase])[23:0];
            m_exp[m_phase] <= ref_norm(m_ops[m_phase])[33:24];
            m_sgn[m_phase] <= m_ops[m_phase][31];
            m_phase        <= m_phase + 1;
        end else begin
            m_phase <= -1;
        end
    end

    logic        e_busy;
    logic [31:0] e_op;
    logic [23:0] d_man [3];
    logic [9:0]  d_exp [3];
    logic        d_sgn [3];

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = (m_phase >= 0) && (m_phase < m_eff);
            e_op   = 32'h0;
            if (e_busy) e_op = m_ops[m_phase];
            d_man[0] = man_a; d_man[1] = man_b; d_man[2] = man_c;
            d_exp[0] = exp_a; d_exp[1] = exp_b; d_exp[2] = exp_c;
            d_sgn[0] = sgn_a; d_sgn[1] = sgn_b; d_sgn[2] = sgn_c;
            chk("ready", ready, m_phase < 0);
            chk("busy", busy, e_busy);
            chk("done", done, (m_phase >= 0) && (m_phase == m_eff) && !kill);
            chk("pn_zero", pn_zero, e_busy && (e_op[30:0] == 31'h0));
            chk("pn_denormal", pn_denormal, e_busy && (e_op[30:23] == 8'h0) && (e_op[22:0] != 23'h0));
            chk("pn_man", pn_man, {(e_op[30:23] != 8'h0), e_op[22:0]});
            chk("pn_exp", pn_exp, e_op[30:23]);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("man_%0d", i), d_man[i], m_man[i]);
                chk($sformatf("exp_%0d", i), d_exp[i], m_exp[i]);
                chk($sformatf("sgn_%0d", i), d_sgn[i], m_sgn[i]);
            end
        end
    end

    // Called #1 after the accept edge; latency 1 means done in that cycle.
    task automatic wait_done(input int req_lat, input string name);
        int lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, req_lat);
        @(posedge clk); #1;
        chk({name, "_ready_after"}, ready, 1'b1);
    endtask

    task automatic run_op(input logic [1:0] cnt, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input int req_lat, input string name);
        op_cnt = cnt; op_a = a; op_b = b; op_c = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operand changes after acceptance must not matter.
        op_a = ~a; op_b = ~b; op_c = ~c;
        wait_done(req_lat, name);
        $display("op %s cnt=%0d a=%08h b=%08h c=%08h", name, cnt, a, b, c);
    endtask

    initial begin
        int lat;
        #1 n_reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_man_a", man_a, 24'h0);
        chk("rst_exp_b", exp_b, 10'h0);
        chk("rst_pn_man", pn_man, 24'h0);
        n_reset = 1'b1;
        @(posedge clk); #1;

        run_op(2'd1, 32'h3F800000, 32'h12345678, 32'h9ABCDEF0, 2, "one");
        chk("one_man_a", man_a, 24'h800000);
        chk("one_exp_a", exp_a, 10'h000);
        chk("one_sgn_a", sgn_a, 1'b0);

        run_op(2'd3, 32'h40400000, 32'h00000001, 32'h80000000, 4, "three");
        chk("three_man_a", man_a, 24'hC00000);
        chk("three_exp_a", exp_a, 10'h001);
        chk("three_man_b", man_b, 24'h800000);
        chk("three_exp_b", exp_b, 10'h36B);
        chk("three_man_c", man_c, 24'h0);
        chk("three_exp_c", exp_c, 10'h0);
        chk("three_sgn_c", sgn_c, 1'b1);

        run_op(2'd0, 32'h3F000000, 32'h3F000000, 32'h3F000000, 1, "zero_cnt");
        chk("zero_cnt_man_a", man_a, 24'hC00000);
        chk("zero_cnt_exp_b", exp_b, 10'h36B);

        run_op(2'd2, 32'h7F800000, 32'hC0000000, 32'h3F800000, 3, "inf_neg");
        chk("inf_man_a", man_a, 24'h800000);
        chk("inf_exp_a", exp_a, 10'h080);
        chk("neg_sgn_b", sgn_b, 1'b1);
        chk("neg_exp_b", exp_b, 10'h001);
        chk("inf_sgn_c_kept", sgn_c, 1'b1);

        // Flush during NORM_B.
        op_cnt = 2'd3; op_a = 32'h3F000000; op_b = 32'h40A00000; op_c = 32'h00400000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("kill_in_norm_b", busy, 1'b1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_ready", ready, 1'b1);
        chk("kill_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("kill_no_done", done, 1'b0);
            @(posedge clk); #1;
        end
        chk("kill_man_a", man_a, 24'h800000);
        chk("kill_exp_a", exp_a, 10'h3FF);
        chk("kill_man_b_kept", man_b, 24'h800000);
        chk("kill_exp_b_kept", exp_b, 10'h001);
        $display("op kill cnt=3 a=3f000000 b=40a00000 c=00400000 flushed in NORM_B");

        // kill together with start in IDLE.
        op_cnt = 2'd1; op_a = 32'h40A00000;
        kill = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        chk("killstart_ready", ready, 1'b1);
        chk("killstart_busy", busy, 1'b0);
        $display("op kill+start in idle ignored");

        // start held high across an operation, then back-to-back.
        op_cnt = 2'd1; op_a = 32'h40A00000;
        start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_first_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk("b2b_first_done", done, 1'b1);
        chk("b2b_first_ready", ready, 1'b0);
        chk("b2b_first_man_a", man_a, 24'hA00000);
        chk("b2b_first_exp_a", exp_a, 10'h002);
        op_a = 32'h00400000;
        @(posedge clk); #1;
        chk("b2b_idle_ready", ready, 1'b1);
        @(posedge clk); #1;
        chk("b2b_second_busy", busy, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_second_done", done, 1'b1);
        chk("b2b_second_man_a", man_a, 24'h800000);
        chk("b2b_second_exp_a", exp_a, 10'h381);
        @(posedge clk); #1;
        $display("op back-to-back a=40a00000 then a=00400000");

        // Async reset during NORM_C.
        op_cnt = 2'd3; op_a = 32'h40400000; op_b = 32'h40A00000; op_c = 32'h3F800000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid_busy", busy, 1'b1);
        chk("rstmid_man_a_loaded", man_a, 24'hC00000);
        #1 n_reset = 1'b0;
        #1;
        chk("rstmid_ready", ready, 1'b1);
        chk("rstmid_busy0", busy, 1'b0);
        chk("rstmid_done", done, 1'b0);
        chk("rstmid_man_a", man_a, 24'h0);
        chk("rstmid_exp_b", exp_b, 10'h0);
        chk("rstmid_sgn_c", sgn_c, 1'b0);
        chk("rstmid_pn_man", pn_man, 24'h0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_after_done", done, 1'b0);
        $display("op reset asserted in NORM_C");

        // NUM_OPS=2 instance clamps op_cnt=3 to two slots.
        chk("n2_ready", ready_2, 1'b1);
        op_cnt = 2'd3; op_a = 32'h3F800000; op_b = 32'h40400000; op_c = 32'h40A00000;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("n2_busy", busy_2, 1'b1);
        lat = 1;
        while (!done_2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("n2_latency", lat, 3);
        chk("n2_man_a", man_a_2, 24'h800000);
        chk("n2_exp_a", exp_a_2, 10'h000);
        chk("n2_man_b", man_b_2, 24'hC00000);
        chk("n2_exp_b", exp_b_2, 10'h001);
        chk("n2_man_c", man_c_2, 24'h0);
        chk("n2_exp_c", exp_c_2, 10'h0);
        chk("n2_sgn", {sgn_a_2, sgn_b_2, sgn_c_2}, 3'b000);
        $display("op num_ops2 cnt=3 a=3f800000 b=40400000 c=40a00000");
        @(posedge clk); #1;

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
